// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider; master drives operands, slave returns results.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_sub_stage.sv
// Combinational WIDTH+1-bit trial subtractor built as a ripple of full-subtractor cells.
module seq_divider_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           borrow_out
);

  always_comb begin
    logic b;
    b          = 1'b0;
    difference = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      difference[i] = minuend[i] ^ subtrahend[i] ^ b;
      b = (~minuend[i] & subtrahend[i]) | (~(minuend[i] ^ subtrahend[i]) & b);
    end
    borrow_out = b;
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_BY_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             unused_diff_msb;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign partial = {rem_q, quo_q[WIDTH-1]};

  seq_divider_sub_stage #(
    .WIDTH (WIDTH)
  ) sub_stage (
    .minuend    (partial),
    .subtrahend ({1'b0, dvs_q}),
    .difference (diff),
    .borrow_out (borrow)
  );

  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          quo_d   = bus.dividend;
          rem_d   = '0;
          dvs_d   = bus.divisor;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = StRun;
`ifdef DIV_BY_ZERO_CHECK_EN
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        rem_d = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef DIV_BY_ZERO_CHECK_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=8.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(
    .WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DIV_BY_ZERO_CHECK_EN
  localparam bit ZeroCheck = 1'b1;
`else
  localparam bit ZeroCheck = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_done"}, 32'(bus.done), 0);
    check_eq({tag, "_q"}, 32'(bus.quotient), 0);
    check_eq({tag, "_r"}, 32'(bus.remainder), 0);
    check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 0);
  endtask

  // Called at posedge+1; the following edge is the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = int'(bus.busy);
    while (!bus.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      bcnt += int'(bus.busy);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er);
    int cyc, bcnt, exp_cyc;
    bit exp_dbz;
    exp_dbz = ZeroCheck && (b == 8'd0);
    exp_cyc = exp_dbz ? 0 : 8;
    launch(a, b);
    wait_done(cyc, bcnt);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_busycyc"}, 32'(bcnt), 32'(exp_cyc));
    check_eq({tag, "_done"}, 32'(bus.done), 1);
    check_eq({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    check_eq({tag, "_r"}, 32'(bus.remainder), 32'(er));
    check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int cyc, bcnt;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("d100_7", 8'd100, 8'd7, 8'd14, 8'd2);
    @(posedge clk);
    #1;
    check_eq("d100_7_done_pulse", 32'(bus.done), 0);
    check_eq("d100_7_hold_q", 32'(bus.quotient), 14);
    check_eq("d100_7_hold_r", 32'(bus.remainder), 2);

    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    @(posedge clk);
    #1;
    run("d5_10", 8'd5, 8'd10, 8'd0, 8'd5);
    @(posedge clk);
    #1;
    run("d255_255", 8'd255, 8'd255, 8'd1, 8'd0);
    @(posedge clk);
    #1;

    run("d42_0", 8'd42, 8'd0, 8'd255, 8'd42);
    @(posedge clk);
    #1;
    check_eq("d42_0_done_pulse", 32'(bus.done), 0);
    check_eq("d42_0_dbz_hold", 32'(bus.div_by_zero), 32'(ZeroCheck));
    check_eq("d42_0_busy_after", 32'(bus.busy), 0);

    // Second start at E3 lands mid-run and must be ignored.
    launch(8'd200, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    launch(8'd9, 8'd4);
    wait_done(cyc, bcnt);
    check_eq("ignore_latency", 32'(cyc), 5);
    check_eq("ignore_q", 32'(bus.quotient), 66);
    check_eq("ignore_r", 32'(bus.remainder), 2);
    check_eq("ignore_dbz", 32'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;
    check_eq("ignore_no_rerun", 32'(bus.busy), 0);

    run("b2b_a", 8'd9, 8'd4, 8'd2, 8'd1);
    run("b2b_b", 8'd50, 8'd6, 8'd8, 8'd2);
    @(posedge clk);
    #1;
    check_eq("b2b_idle_done", 32'(bus.done), 0);
    check_eq("b2b_idle_busy", 32'(bus.busy), 0);

    // Reset asserted at E4 of 100/7 must clear everything at once.
    launch(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy", 32'(bus.busy), 1);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("postrst");
    run("d7_2", 8'd7, 8'd2, 8'd3, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
